pulse_req_tx: RTL and testbench

//   Source-side (clk1) transmitter of a 4-phase req/ack pulse-crossing link. Converts

---
 rtl/pulse_req_tx.sv | 195 +++++++++++++++++++
 tb/tb_pulse_req_tx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_req_tx.sv
// pulse_req_tx - source-side (clk1) transmitter of a 4-phase req/ack
// pulse-crossing link. Each accepted pulse_in becomes one held request level
// on sig1. Events that arrive faster than the handshake round trip are held
// in a saturating pending counter. When it is full, further events are
// dropped and the sticky ovf flag is set.
//
// Optional feature macro: PULSE_TX_TIMEOUT_EN
//   defined   : a phase counter flags (sticky) a REQ or DROP phase that lasts
//               TIMEOUT_CYC cycles. The handshake itself keeps waiting.
//   undefined : timeout is tied low and no phase counter exists.
module pulse_req_tx #(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk1,
  input  logic             rstn,
  input  logic             pulse_in,
  input  logic             ack_in,
  input  logic             err_clr,
  output logic             sig1,
  output logic             busy,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             ovf,
  output logic             timeout
);

  // Reject configurations the synchroniser or the phase counter cannot honour.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pulse_req_tx: SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("pulse_req_tx: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

  state_t                 state_r;
  state_t                 state_n;
  logic                   sig1_r;
  logic [CNT_W-1:0]       pend_cnt_r;
  logic [CNT_W-1:0]       pend_cnt_n;
  logic                   ovf_r;
  logic [SYNC_STAGES-1:0] ack_sync_r;
  logic                   ack_s;
  logic                   pend_nz_s;
  logic                   launch_s;
  logic                   drop_s;

  assign ack_s     = ack_sync_r[SYNC_STAGES-1];
  assign pend_nz_s = |pend_cnt_r;

  // Bring the asynchronous ack level into clk1; nothing else looks at ack_in.
  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      ack_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      ack_sync_r <= {ack_sync_r[SYNC_STAGES-2:0], ack_in};
    end
  end

  // Handshake sequencing. A launch can only leave IDLE, where ack_s is already low.
  always_comb begin
    state_n  = state_r;
    launch_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pend_nz_s || pulse_in) begin
          state_n  = REQ;
          launch_s = 1'b1;
        end else begin
          state_n  = IDLE;
        end
      end
      REQ: begin
        if (ack_s) begin
          state_n = DROP;
        end else begin
          state_n = REQ;
        end
      end
      DROP: begin
        if (!ack_s) begin
          state_n = IDLE;
        end else begin
          state_n = DROP;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Pending-count update: a pulse that is launched at once (bypass, or paired
  // with a launch from the queue) leaves the count alone; a full queue drops it.
  always_comb begin
    pend_cnt_n = pend_cnt_r;
    drop_s     = 1'b0;
    if (pulse_in) begin
      if (launch_s) begin
        pend_cnt_n = pend_cnt_r;
      end else if (pend_cnt_r == CNT_MAX) begin
        pend_cnt_n = pend_cnt_r;
        drop_s     = 1'b1;
      end else begin
        pend_cnt_n = pend_cnt_r + CNT_ONE;
      end
    end else if (launch_s && pend_nz_s) begin
      pend_cnt_n = pend_cnt_r - CNT_ONE;
    end else begin
      pend_cnt_n = pend_cnt_r;
    end
  end

  // State register; sig1 gets its own flop so the request line is glitch-free.
  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
      sig1_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      sig1_r  <= (state_n == REQ);
    end
  end

  // Queue depth and the sticky overflow flag (a new drop beats err_clr).
  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      pend_cnt_r <= {CNT_W{1'b0}};
      ovf_r      <= 1'b0;
    end else begin
      pend_cnt_r <= pend_cnt_n;
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (err_clr) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

`ifdef PULSE_TX_TIMEOUT_EN
  localparam int               TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]  TO_LIM = TO_W'(TIMEOUT_CYC);
  localparam logic [TO_W-1:0]  TO_ONE = TO_W'(32'd1);

  logic [TO_W-1:0] phase_cnt_r;
  logic            timeout_r;

  // Cycles spent in the current REQ/DROP phase, restarted on every state change.
  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      phase_cnt_r <= {TO_W{1'b0}};
    end else if (state_n != state_r) begin
      phase_cnt_r <= {TO_W{1'b0}};
    end else if ((state_r != IDLE) && (phase_cnt_r != TO_LIM)) begin
      phase_cnt_r <= phase_cnt_r + TO_ONE;
    end else begin
      phase_cnt_r <= phase_cnt_r;
    end
  end

  // Sticky timeout flag; only reports, the handshake keeps waiting for ack.
  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      timeout_r <= 1'b0;
    end else if (phase_cnt_r == TO_LIM) begin
      timeout_r <= 1'b1;
    end else if (err_clr) begin
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= timeout_r;
    end
  end

  assign timeout = timeout_r;
`else
  assign timeout = 1'b0;
`endif

  assign sig1     = sig1_r;
  assign pend_cnt = pend_cnt_r;
  assign ovf      = ovf_r;
  assign busy     = (state_r != IDLE) | pend_nz_s;

endmodule

// File: tb/tb_pulse_req_tx.sv
// tb_pulse_req_tx - bench for pulse_req_tx. The destination side is modelled
// as two clk2 flops on sig1 (its output is ack_in) plus a rising-edge
// detector that counts delivered pulses. A transaction-level reference model
// tracks queue depth, handshake phase and sticky flags per clk1 cycle.
// Compile with PULSE_TX_TIMEOUT_EN to cover the timeout feature.
module tb_pulse_req_tx;

  localparam int CNT_W  = 4;
  localparam int SYNC   = 2;
  localparam int TO_CYC = 16;
  localparam int MAXQ   = (1 << CNT_W) - 1;

  logic             clk1 = 1'b0;
  logic             clk2 = 1'b0;
  logic             rstn;
  logic             pulse_in;
  logic             ack_in;
  logic             err_clr;
  logic             sig1;
  logic             busy;
  logic [CNT_W-1:0] pend_cnt;
  logic             ovf;
  logic             timeout;

  int   half2    = 15;
  logic ack_hold = 1'b0;
  logic chk_en   = 1'b0;
  int   checks   = 0;
  int   passes   = 0;
  int   peak     = 0;

  pulse_req_tx #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk1    (clk1),
    .rstn    (rstn),
    .pulse_in(pulse_in),
    .ack_in  (ack_in),
    .err_clr (err_clr),
    .sig1    (sig1),
    .busy    (busy),
    .pend_cnt(pend_cnt),
    .ovf     (ovf),
    .timeout (timeout)
  );

  // clk1 posedges fall on odd ns, clk2 posedges on even ns: the two never coincide.
  always #5 clk1 = ~clk1;

  initial begin
    #2;
    forever begin
      clk2 = 1'b1;
      #(half2);
      clk2 = 1'b0;
      #(half2);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end else begin
      passes++;
    end
  endtask

  // ---------------- destination-domain model ----------------
  logic d1, d2, d3;
  int   dest_cnt;
  assign ack_in = d2;

  always @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      d1 <= 1'b0; d2 <= 1'b0; d3 <= 1'b0;
    end else if (!ack_hold) begin
      d1 <= sig1; d2 <= d1; d3 <= d2;
    end
  end

  // Count delivered pulses; a pulse with no accepted event behind it is a duplicate.
  always @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      dest_cnt <= 0;
    end else if (!ack_hold && d2 && !d3) begin
      chk("dest_no_dup", (dest_cnt < m_acc), 1);
      dest_cnt <= dest_cnt + 1;
    end
  end

  // ---------------- reference model ----------------
  // m_phase: 0 no handshake, 1 request raised, 2 request withdrawn awaiting ack low.
  int              m_pend, m_phase, m_acc, m_wait;
  logic            m_ovf, m_to;
  logic [SYNC-1:0] m_hist;

  always @(posedge clk1 or negedge rstn) begin : model
    logic ack_seen, launch, drop;
    int   np, nph;
    if (!rstn) begin
      m_pend <= 0; m_phase <= 0; m_acc <= 0; m_wait <= 0;
      m_ovf <= 1'b0; m_to <= 1'b0; m_hist <= '0;
    end else begin
      ack_seen = m_hist[SYNC-1];
      launch   = (m_phase == 0) && ((m_pend != 0) || pulse_in);
      drop     = 1'b0;
      np       = m_pend;
      if (pulse_in && !launch) begin
        if (m_pend == MAXQ) drop = 1'b1;
        else                np   = m_pend + 1;
      end else if (!pulse_in && launch) begin
        np = m_pend - 1;
      end
      nph = m_phase;
      if (launch)                         nph = 1;
      else if (m_phase == 1 && ack_seen)  nph = 2;
      else if (m_phase == 2 && !ack_seen) nph = 0;
      m_pend  <= np;
      m_phase <= nph;
      m_acc   <= m_acc + ((pulse_in && !drop) ? 1 : 0);
      m_hist  <= {m_hist[SYNC-2:0], ack_in};
      m_ovf   <= drop ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
`ifdef PULSE_TX_TIMEOUT_EN
      if (nph != m_phase)                    m_wait <= 0;
      else if (m_phase != 0 && m_wait < TO_CYC) m_wait <= m_wait + 1;
      m_to <= (m_wait == TO_CYC) ? 1'b1 : (err_clr ? 1'b0 : m_to);
`endif
    end
  end

  // Per-cycle comparison of every output against the model, away from the active edge.
  always @(negedge clk1) begin
    if (chk_en) begin
      chk("cyc_sig1", sig1, (m_phase == 1));
      chk("cyc_busy", busy, (m_phase != 0) || (m_pend != 0));
      chk("cyc_pend", pend_cnt, m_pend);
      chk("cyc_ovf", ovf, m_ovf);
      chk("cyc_timeout", timeout, m_to);
    end
    if (int'(pend_cnt) > peak) peak = int'(pend_cnt);
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_in = 1'b1;
      @(negedge clk1);
    end
    pulse_in = 1'b0;
  endtask

  task automatic set_hold(input logic v);
    #1 ack_hold = v;
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk1);
      if (!busy && m_phase == 0) break;
    end
    chk("drain_busy", busy, 0);
    repeat (4) @(negedge clk1);
  endtask

  typedef struct {
    int   n;
    logic hold;
    logic clr;
    int   exp_peak;
    logic exp_ovf;
    int   exp_dest;
  } vec_t;

  vec_t tbl[5];
  int   d0;

  initial begin
    tbl[0] = '{n: 1,  hold: 1'b0, clr: 1'b0, exp_peak: 0,  exp_ovf: 1'b0, exp_dest: 1};
    tbl[1] = '{n: 5,  hold: 1'b0, clr: 1'b0, exp_peak: 4,  exp_ovf: 1'b0, exp_dest: 5};
    tbl[2] = '{n: 3,  hold: 1'b1, clr: 1'b0, exp_peak: 2,  exp_ovf: 1'b0, exp_dest: 3};
    tbl[3] = '{n: 16, hold: 1'b1, clr: 1'b0, exp_peak: 15, exp_ovf: 1'b0, exp_dest: 16};
    tbl[4] = '{n: 20, hold: 1'b1, clr: 1'b1, exp_peak: 15, exp_ovf: 1'b1, exp_dest: 16};

    rstn = 1'b0; pulse_in = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk1);
    chk("rst_sig1", sig1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pend", pend_cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_timeout", timeout, 0);
    #1 rstn = 1'b1;
    chk_en = 1'b1;
    repeat (9) @(negedge clk1);

    // Single-cycle latency from an idle pulse to the request level.
    chk("lat_pre_sig1", sig1, 0);
    pulse_in = 1'b1;
    @(negedge clk1);
    pulse_in = 1'b0;
    chk("lat_sig1", sig1, 1);
    chk("lat_pend", pend_cnt, 0);
    chk("lat_busy", busy, 1);
    wait_idle(500);

    // Burst table, slow destination clock.
    for (int i = 0; i < 5; i++) begin
      set_hold(tbl[i].hold);
      @(negedge clk1);
      d0   = dest_cnt;
      peak = 0;
      send(tbl[i].n);
      repeat (3) @(negedge clk1);
      set_hold(1'b0);
      wait_idle(2000);
      chk("tbl_peak", peak, tbl[i].exp_peak);
      chk("tbl_ovf", ovf, tbl[i].exp_ovf);
      chk("tbl_dest", dest_cnt - d0, tbl[i].exp_dest);
      if (tbl[i].clr) begin
        err_clr = 1'b1;
        @(negedge clk1);
        err_clr = 1'b0;
        chk("tbl_ovf_clr", ovf, 0);
      end
    end

    // A pulse in the IDLE cycle that also launches from a queue of 2 leaves it at 2.
    set_hold(1'b1);
    @(negedge clk1);
    send(3);
    set_hold(1'b0);
    begin : find_idle
      int k;
      for (k = 0; k < 1000; k++) begin
        @(negedge clk1);
        if (m_phase == 0 && m_pend == 2) break;
      end
      chk("cancel_found", (k < 1000), 1);
    end
    pulse_in = 1'b1;
    @(negedge clk1);
    pulse_in = 1'b0;
    chk("cancel_pend", pend_cnt, 2);
    chk("cancel_sig1", sig1, 1);
    wait_idle(3000);

    // Asynchronous reset in the middle of a request.
    set_hold(1'b1);
    @(negedge clk1);
    send(3);
    repeat (2) @(negedge clk1);
    #3 rstn = 1'b0;
    #1;
    chk("arst_sig1", sig1, 0);
    chk("arst_pend", pend_cnt, 0);
    chk("arst_busy", busy, 0);
    ack_hold = 1'b0;
    @(negedge clk1);
    #1 rstn = 1'b1;
    @(negedge clk1);
    send(1);
    wait_idle(500);
    chk("arst_dest", dest_cnt, 1);

`ifdef PULSE_TX_TIMEOUT_EN
    // Stuck ack: timeout flags but the request is held and later completes.
    set_hold(1'b1);
    @(negedge clk1);
    d0 = dest_cnt;
    send(1);
    repeat (20) @(negedge clk1);
    chk("to_set", timeout, 1);
    chk("to_sig1_held", sig1, 1);
    set_hold(1'b0);
    wait_idle(500);
    chk("to_dest", dest_cnt - d0, 1);
    err_clr = 1'b1;
    @(negedge clk1);
    err_clr = 1'b0;
    chk("to_clr", timeout, 0);
`else
    chk("to_tied", timeout, 0);
`endif

    // Randomised traffic at both clock ratios.
    for (int ph = 0; ph < 2; ph++) begin
      @(negedge clk1);
      half2 = (ph == 0) ? 15 : 2;
      d0 = dest_cnt;
      for (int c = 0; c < 1500; c++) begin
        pulse_in = ($urandom_range(0, 99) < 40);
        err_clr  = ($urandom_range(0, 99) < 3);
        if ($urandom_range(0, 149) == 0) set_hold(~ack_hold);
        @(negedge clk1);
      end
      pulse_in = 1'b0;
      err_clr  = 1'b0;
      set_hold(1'b0);
      wait_idle(3000);
      chk("rand_dest_total", dest_cnt, m_acc);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
